magnetron_power_ctrl: RTL and testbench
=======================================

// Module: magnetron_power_ctrl
// PURPOSE
//  Next-generation magnetron controller. Replaces the plain start/stop/clear latch with a clocked FSM that adds
//  selectable power levels, pause/resume, a door interlock and an end-of-cook beep.
//  Power is delivered by duty-cycling mag_on over a fixed modulation period.
//  Sits between the keypad/timer block (startn, stopn, clearn, timer_done) and the magnetron driver.
// PARAMETERS
//  PERIOD      10  modulation period in clk cycles; must be a multiple of LEVELS and >= 2
//  LEVELS      5   number of nonzero power levels; duty step = PERIOD/LEVELS cycles
//  BEEP_CYCLES 4   number of cycles done_beep stays high after timer_done
// PORTS
//  clk          in   1                 system clock; all logic is on the rising edge
//  rst          in   1                 synchronous, active-high reset
//  startn       in   1                 start/resume request, active low; the falling edge is the event
//  stopn        in   1                 stop/pause request, active low, level
//  clearn       in   1                 clear, active low, level; highest priority
//  door_closed  in   1                 1 = door closed
//  timer_done   in   1                 cook timer expired, level
//  power_level  in   $clog2(LEVELS+1)  requested level 0..LEVELS; values above LEVELS saturate to LEVELS
//  mag_on       out  1                 magnetron enable (registered)
//  cooking      out  1                 state == COOK
//  paused       out  1                 state == PAUSE
//  done_beep    out  1                 high while state == DONE
// BEHAVIOUR
//  - Reset: state IDLE; mag_on=0, cooking=0, paused=0, done_beep=0; phase counter 0; startn edge register = 1.
//  - start_evt = previous startn==1 && startn==0. Holding startn low produces no further events.
//  - States: IDLE, COOK, PAUSE, DONE. Per-cycle priority (highest first):
//      1. clearn==0: -> IDLE from any state.
//      2. stopn==0:  COOK -> PAUSE; PAUSE -> IDLE; IDLE and DONE unchanged.
//      3. timer_done==1 in COOK or PAUSE: -> DONE.
//      4. door_closed==0 in COOK: -> PAUSE.
//      5. start_evt && door_closed: IDLE -> COOK; PAUSE -> COOK. A start with the door open is ignored.
//  - DONE: beep counter loads BEEP_CYCLES-1 on entry and decrements each cycle; at 0 -> IDLE.
//    clearn aborts DONE immediately.
//  - Modulation:
//      - The phase counter runs 0..PERIOD-1 only while in COOK, then wraps.
//      - The counter resets to 0 on every entry to COOK, so a resume restarts the period.
//      - lvl_q is latched from saturated power_level on COOK entry and again whenever phase wraps to 0.
//      - on_cycles = lvl_q * (PERIOD/LEVELS).
//      - mag_on(next) = next_state==COOK && next_phase < on_cycles && door_closed.
//      - Level 0 gives mag_on always 0. Level LEVELS gives mag_on constantly 1.
//  - Latency: mag_on, cooking and paused rise on the clock edge that registers the qualifying input.
//    There is no combinational input-to-output path.
//  - Interlock: mag_on can never be 1 in a cycle that follows a sampled door_closed==0.
//  - rst asserted mid-cook: outputs go to their reset values on the next edge. Any pending start edge is lost.
// STRUCTURE
//  - Shared package magnetron_pkg: state encoding typedef (IDLE=0, COOK=1, PAUSE=2, DONE=3) and a saturating
//    level function. Both are reused by the display and timer blocks.
//  - One sub-module, pwm_phase_gen: phase counter, level latch and compare; produces on_now.
//  - The top level holds the FSM, the startn edge detector and the beep counter.
// TESTING  (PERIOD=10, LEVELS=5, BEEP_CYCLES=4)
//  1. door=1, power_level=3, startn pulsed low:
//     -> COOK; mag_on is high 6 cycles then low 4, repeating for 3 periods.
//  2. Mid-cook stopn=0 for 1 cycle -> PAUSE, mag_on=0.
//     startn falling edge -> COOK with phase restarted (6 on / 4 off).
//     A second stopn pulse while paused -> IDLE.
//  3. Door opens mid-COOK -> PAUSE and mag_on=0 next edge.
//     startn edge while door=0 -> stays PAUSE. Close door, then startn edge -> COOK.
//  4. timer_done=1 in COOK -> DONE with done_beep high exactly 4 cycles, then IDLE.
//     Repeat with clearn=0 on the 2nd DONE cycle -> IDLE next edge.
//  5. Simultaneous events in COOK: clearn=0, stopn=0 and timer_done=1 together -> IDLE.
//     stopn=0 with timer_done=1 -> PAUSE (stop outranks timer). Hold startn low 20 cycles -> only one start event.
//  6. power_level=7 -> mag_on constantly 1. power_level changed 5->0 mid-period -> takes effect at next wrap.
//     rst asserted mid-cook -> all outputs 0 next edge.

Source files
------------

// File: rtl/magnetron_pkg.sv
// Shared definitions for the magnetron controller, display and timer blocks.
package magnetron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Clamp a requested power level to the highest supported level.
    function automatic int unsigned sat_level(input int unsigned req, input int unsigned max_lvl);
        return (req > max_lvl) ? max_lvl : req;
    endfunction

endpackage

// File: rtl/magnetron_power_ctrl_if.sv
// Keypad/timer side signals and magnetron driver outputs of the power controller.
interface magnetron_power_ctrl_if #(
    parameter int LEVELS = 5
);
    localparam int LW = $clog2(LEVELS + 1);

    logic          startn;
    logic          stopn;
    logic          clearn;
    logic          door_closed;
    logic          timer_done;
    logic [LW-1:0] power_level;
    logic          mag_on;
    logic          cooking;
    logic          paused;
    logic          done_beep;

    modport master (
        output startn, stopn, clearn, door_closed, timer_done, power_level,
        input  mag_on, cooking, paused, done_beep
    );

    modport slave (
        input  startn, stopn, clearn, door_closed, timer_done, power_level,
        output mag_on, cooking, paused, done_beep
    );
endinterface

// File: rtl/pwm_phase_gen.sv
// Modulation phase counter, power level latch and duty compare.
// on_now reports whether the magnetron should be on after the coming edge.
module pwm_phase_gen
    import magnetron_pkg::*;
#(
    parameter int PERIOD = 10,
    parameter int LEVELS = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cook_next,
    input  logic                           cook_entry,
    input  logic [$clog2(LEVELS+1)-1:0]    power_level,
    output logic                           on_now
);
    localparam int STEP = PERIOD / LEVELS;
    localparam int PW   = $clog2(PERIOD);
    localparam int LW   = $clog2(LEVELS + 1);

    logic [PW-1:0] phase_q, phase_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic [LW-1:0] lvl_sat;
    logic          wrap;
    logic [31:0]   on_cycles;

    assign lvl_sat = LW'(sat_level(32'(power_level), LEVELS));
    assign wrap    = (phase_q == PW'(PERIOD - 1));

    // Next phase/level; the compare uses the post-edge values so mag_on is aligned with phase.
    always_comb begin
        phase_d = '0;
        lvl_d   = lvl_q;
        if (cook_entry) begin
            lvl_d = lvl_sat;
        end else if (cook_next) begin
            phase_d = wrap ? '0 : phase_q + 1'b1;
            if (wrap) begin
                lvl_d = lvl_sat;
            end
        end
        on_cycles = 32'(lvl_d) * 32'(STEP);
        on_now    = cook_next && (32'(phase_d) < on_cycles);
    end

    // Phase and level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            lvl_q   <= '0;
        end else begin
            phase_q <= phase_d;
            lvl_q   <= lvl_d;
        end
    end
endmodule

// File: rtl/magnetron_power_ctrl.sv
// Magnetron power controller: cook/pause/done FSM, start edge detector,
// end-of-cook beep timer and duty-cycled magnetron enable.
module magnetron_power_ctrl
    import magnetron_pkg::*;
#(
    parameter int PERIOD      = 10,
    parameter int LEVELS      = 5,
    parameter int BEEP_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    magnetron_power_ctrl_if.slave  bus
);
    localparam int BW = $clog2(BEEP_CYCLES + 1);

    state_t        state, state_d;
    logic          startn_q;
    logic          start_evt;
    logic          on_now;
    logic [BW-1:0] beep_cnt;

    assign start_evt = startn_q & ~bus.startn;

    // Next state; DONE only listens to clear and its own beep countdown.
    always_comb begin
        state_d = state;
        if (state == DONE) begin
            if (!bus.clearn || beep_cnt == '0) begin
                state_d = IDLE;
            end
        end else if (!bus.clearn) begin
            state_d = IDLE;
        end else if (!bus.stopn) begin
            if (state == COOK) begin
                state_d = PAUSE;
            end else if (state == PAUSE) begin
                state_d = IDLE;
            end
        end else if (bus.timer_done && (state == COOK || state == PAUSE)) begin
            state_d = DONE;
        end else if (!bus.door_closed && state == COOK) begin
            state_d = PAUSE;
        end else if (start_evt && bus.door_closed && (state == IDLE || state == PAUSE)) begin
            state_d = COOK;
        end
    end

    pwm_phase_gen #(
        .PERIOD (PERIOD),
        .LEVELS (LEVELS)
    ) u_pwm (
        .clk         (clk),
        .rst         (rst),
        .cook_next   (state_d == COOK),
        .cook_entry  (state_d == COOK && state != COOK),
        .power_level (bus.power_level),
        .on_now      (on_now)
    );

    // State, edge detector, beep counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            startn_q      <= 1'b1;
            beep_cnt      <= '0;
            bus.mag_on    <= 1'b0;
            bus.cooking   <= 1'b0;
            bus.paused    <= 1'b0;
            bus.done_beep <= 1'b0;
        end else begin
            state    <= state_d;
            startn_q <= bus.startn;
            if (state_d == DONE && state != DONE) begin
                beep_cnt <= BW'(BEEP_CYCLES - 1);
            end else if (state == DONE && beep_cnt != '0) begin
                beep_cnt <= beep_cnt - 1'b1;
            end
            bus.mag_on    <= on_now && bus.door_closed;
            bus.cooking   <= (state_d == COOK);
            bus.paused    <= (state_d == PAUSE);
            bus.done_beep <= (state_d == DONE);
        end
    end
endmodule

// File: tb/tb_magnetron_power_ctrl.sv
// Scenario and randomized checks of magnetron_power_ctrl against a cycle model
// built from the controller's behavioural rules (PERIOD=10, LEVELS=5, BEEP_CYCLES=4).
module tb_magnetron_power_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: 0 idle, 1 cook, 2 pause, 3 done.
    int   m_st = 0;
    int   m_phase = 0;
    int   m_lvl = 0;
    int   m_left = 0;
    bit   m_prev_startn = 1'b1;
    bit   m_mag = 1'b0;

    magnetron_power_ctrl_if #(.LEVELS(5)) bus ();

    magnetron_power_ctrl #(
        .PERIOD      (10),
        .LEVELS      (5),
        .BEEP_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void model_update();
        bit start;
        int nxt;
        int lv;
        start = m_prev_startn && !bus.startn;
        m_prev_startn = bus.startn;
        lv = (int'(bus.power_level) > 5) ? 5 : int'(bus.power_level);
        if (rst) begin
            m_st = 0; m_phase = 0; m_lvl = 0; m_left = 0; m_mag = 1'b0;
            m_prev_startn = 1'b1;
            return;
        end
        nxt = m_st;
        if (m_st == 3) begin
            m_left--;
            if (!bus.clearn || m_left == 0) nxt = 0;
        end else if (!bus.clearn) nxt = 0;
        else if (!bus.stopn) begin
            if (m_st == 1) nxt = 2;
            else if (m_st == 2) nxt = 0;
        end
        else if (bus.timer_done && (m_st == 1 || m_st == 2)) nxt = 3;
        else if (!bus.door_closed && m_st == 1) nxt = 2;
        else if (start && bus.door_closed && (m_st == 0 || m_st == 2)) nxt = 1;
        if (nxt == 3 && m_st != 3) m_left = 4;
        if (nxt == 1) begin
            if (m_st != 1) begin
                m_phase = 0;
                m_lvl = lv;
            end else begin
                m_phase = (m_phase + 1) % 10;
                if (m_phase == 0) m_lvl = lv;
            end
        end
        m_mag = (nxt == 1) && (m_phase < m_lvl * 2) && bus.door_closed;
        m_st = nxt;
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic go_idle();
        bus.clearn = 1'b0;
        cyc();
        bus.clearn = 1'b1;
    endtask

    task automatic start_pulse();
        bus.startn = 1'b0;
        cyc();
        bus.startn = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        n_tests++;
        if ({bus.mag_on, bus.cooking, bus.paused, bus.done_beep} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset: outputs=%b expected 0000",
                     {bus.mag_on, bus.cooking, bus.paused, bus.done_beep});
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_duty(input int lvl);
        int  sl;
        logic e;
        sl = (lvl > 5) ? 5 : lvl;
        go_idle();
        bus.door_closed = 1'b1;
        bus.power_level = 3'(lvl);
        start_pulse();
        for (int i = 0; i < 30; i++) begin
            if (i > 0) cyc();
            e = ((i % 10) < sl * 2);
            n_tests++;
            if (bus.mag_on !== e || bus.cooking !== 1'b1) begin
                n_fail++;
                $display("FAIL duty_l%0d cycle %0d: mag_on=%b cooking=%b expected %b/1",
                         lvl, i, bus.mag_on, bus.cooking, e);
            end
        end
    endtask

    task automatic test_pause_resume();
        logic e;
        go_idle();
        bus.power_level = 3'd3;
        start_pulse();
        repeat ($urandom_range(1, 15)) cyc();
        bus.stopn = 1'b0;
        cyc();
        bus.stopn = 1'b1;
        n_tests++;
        if ({bus.mag_on, bus.cooking, bus.paused} !== 3'b001) begin
            n_fail++;
            $display("FAIL pause: mag/cook/pause=%b expected 001", {bus.mag_on, bus.cooking, bus.paused});
        end
        repeat (3) cyc();
        n_tests++;
        if (bus.paused !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_hold: paused=%b expected 1", bus.paused);
        end
        start_pulse();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cyc();
            e = (i < 6);
            n_tests++;
            if (bus.mag_on !== e || bus.cooking !== 1'b1) begin
                n_fail++;
                $display("FAIL resume cycle %0d: mag_on=%b cooking=%b expected %b/1",
                         i, bus.mag_on, bus.cooking, e);
            end
        end
        bus.stopn = 1'b0;
        cyc();
        bus.stopn = 1'b1;
        cyc();
        bus.stopn = 1'b0;
        cyc();
        bus.stopn = 1'b1;
        n_tests++;
        if ({bus.mag_on, bus.cooking, bus.paused, bus.done_beep} !== 4'b0000) begin
            n_fail++;
            $display("FAIL stop_from_pause: outputs=%b expected 0000",
                     {bus.mag_on, bus.cooking, bus.paused, bus.done_beep});
        end
    endtask

    task automatic test_door();
        go_idle();
        bus.power_level = 3'd3;
        start_pulse();
        repeat ($urandom_range(1, 12)) cyc();
        bus.door_closed = 1'b0;
        cyc();
        n_tests++;
        if ({bus.mag_on, bus.cooking, bus.paused} !== 3'b001) begin
            n_fail++;
            $display("FAIL door_open: mag/cook/pause=%b expected 001", {bus.mag_on, bus.cooking, bus.paused});
        end
        start_pulse();
        cyc();
        n_tests++;
        if ({bus.mag_on, bus.cooking, bus.paused} !== 3'b001) begin
            n_fail++;
            $display("FAIL start_door_open: mag/cook/pause=%b expected 001", {bus.mag_on, bus.cooking, bus.paused});
        end
        bus.door_closed = 1'b1;
        cyc();
        start_pulse();
        n_tests++;
        if ({bus.mag_on, bus.cooking, bus.paused} !== 3'b110) begin
            n_fail++;
            $display("FAIL door_resume: mag/cook/pause=%b expected 110", {bus.mag_on, bus.cooking, bus.paused});
        end
    endtask

    task automatic test_done();
        logic e;
        go_idle();
        bus.power_level = 3'd4;
        start_pulse();
        repeat (3) cyc();
        bus.timer_done = 1'b1;
        cyc();
        bus.timer_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            e = (i < 4);
            n_tests++;
            if (bus.done_beep !== e || bus.mag_on !== 1'b0 || bus.cooking !== 1'b0) begin
                n_fail++;
                $display("FAIL beep cycle %0d: done_beep=%b mag_on=%b cooking=%b expected %b/0/0",
                         i, bus.done_beep, bus.mag_on, bus.cooking, e);
            end
        end
        start_pulse();
        bus.timer_done = 1'b1;
        cyc();
        bus.timer_done = 1'b0;
        cyc();
        n_tests++;
        if (bus.done_beep !== 1'b1) begin
            n_fail++;
            $display("FAIL beep_second_cycle: done_beep=%b expected 1", bus.done_beep);
        end
        bus.clearn = 1'b0;
        cyc();
        bus.clearn = 1'b1;
        n_tests++;
        if ({bus.mag_on, bus.cooking, bus.paused, bus.done_beep} !== 4'b0000) begin
            n_fail++;
            $display("FAIL beep_clear: outputs=%b expected 0000",
                     {bus.mag_on, bus.cooking, bus.paused, bus.done_beep});
        end
    endtask

    task automatic test_priority();
        go_idle();
        bus.power_level = 3'd2;
        start_pulse();
        repeat (2) cyc();
        bus.clearn = 1'b0; bus.stopn = 1'b0; bus.timer_done = 1'b1;
        cyc();
        bus.clearn = 1'b1; bus.stopn = 1'b1; bus.timer_done = 1'b0;
        n_tests++;
        if ({bus.mag_on, bus.cooking, bus.paused, bus.done_beep} !== 4'b0000) begin
            n_fail++;
            $display("FAIL prio_clear: outputs=%b expected 0000",
                     {bus.mag_on, bus.cooking, bus.paused, bus.done_beep});
        end
        start_pulse();
        repeat (2) cyc();
        bus.stopn = 1'b0; bus.timer_done = 1'b1;
        cyc();
        bus.stopn = 1'b1; bus.timer_done = 1'b0;
        n_tests++;
        if ({bus.cooking, bus.paused, bus.done_beep} !== 3'b010) begin
            n_fail++;
            $display("FAIL prio_stop_timer: cook/pause/beep=%b expected 010",
                     {bus.cooking, bus.paused, bus.done_beep});
        end
        bus.startn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) bus.stopn = 1'b0;
            cyc();
            bus.stopn = 1'b1;
            n_tests++;
            if (bus.cooking !== (i < 5) || bus.paused !== (i >= 5)) begin
                n_fail++;
                $display("FAIL held_start cycle %0d: cooking=%b paused=%b expected %b/%b",
                         i, bus.cooking, bus.paused, (i < 5), (i >= 5));
            end
        end
        bus.startn = 1'b1;
    endtask

    task automatic test_level();
        go_idle();
        bus.power_level = 3'd7;
        start_pulse();
        for (int i = 0; i < 20; i++) begin
            if (i > 0) cyc();
            n_tests++;
            if (bus.mag_on !== 1'b1) begin
                n_fail++;
                $display("FAIL level_sat cycle %0d: mag_on=%b expected 1", i, bus.mag_on);
            end
        end
        go_idle();
        bus.power_level = 3'd5;
        start_pulse();
        for (int i = 0; i < 20; i++) begin
            if (i > 0) cyc();
            n_tests++;
            if (bus.mag_on !== (i < 10)) begin
                n_fail++;
                $display("FAIL level_change cycle %0d: mag_on=%b expected %b", i, bus.mag_on, (i < 10));
            end
            if (i == 3) bus.power_level = 3'd0;
        end
    endtask

    task automatic test_rst_mid_cook();
        go_idle();
        bus.power_level = 3'd5;
        start_pulse();
        repeat (3) cyc();
        rst = 1'b1;
        bus.startn = 1'b0;
        cyc();
        n_tests++;
        if ({bus.mag_on, bus.cooking, bus.paused, bus.done_beep} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_cook: outputs=%b expected 0000",
                     {bus.mag_on, bus.cooking, bus.paused, bus.done_beep});
        end
        rst = 1'b0;
        bus.startn = 1'b1;
        repeat (2) cyc();
        n_tests++;
        if (bus.cooking !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_lost_start: cooking=%b expected 0", bus.cooking);
        end
    endtask

    task automatic test_random();
        logic [3:0] got, exp;
        for (int i = 0; i < 1500; i++) begin
            bus.startn      = ($urandom % 4) != 0;
            bus.stopn       = ($urandom % 20) != 0;
            bus.clearn      = ($urandom % 50) != 0;
            bus.door_closed = ($urandom % 15) != 0;
            bus.timer_done  = ($urandom % 40) == 0;
            if ($urandom % 25 == 0) bus.power_level = 3'($urandom % 8);
            rst = ($urandom % 300) == 0;
            cyc();
            got = {bus.mag_on, bus.cooking, bus.paused, bus.done_beep};
            exp = {m_mag, m_st == 1, m_st == 2, m_st == 3};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random cycle %0d: mag/cook/pause/beep=%b expected %b", i, got, exp);
            end
        end
        rst = 1'b0;
        bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
        bus.door_closed = 1'b1; bus.timer_done = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.startn      = 1'b1;
        bus.stopn       = 1'b1;
        bus.clearn      = 1'b1;
        bus.door_closed = 1'b1;
        bus.timer_done  = 1'b0;
        bus.power_level = 3'd0;
        test_reset();
        test_duty(3);
        test_duty(int'($urandom_range(0, 7)));
        test_duty(int'($urandom_range(0, 7)));
        test_pause_resume();
        test_door();
        test_done();
        test_priority();
        test_level();
        test_rst_mid_cook();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
